edge_clock_gen: RTL
===================

Name: edge_clock_gen

Overview:
- Clock-domain-local generator producing a slow derived clock `gen_clk` from `clk`, with a programmable half-period and start delay.
- Counts `gen_clk` rising edges, exports the count and its odd/even parity, and stops itself with a `done` pulse once a programmed edge limit is exceeded.
- Serves as the transmit side for posedge-driven consumers in scheduler tests; those consumers see `gen_clk` as their clock or sample `posedge_pulse` as an enable.

Parameters:
- HP_W, 16, width of `cfg_half_period` and `cfg_start_delay`.
- CYC_W, 32, width of `cfg_edge_limit` and `cyc_count`.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin generation; honoured only in IDLE.
- stop  input  1  abort request; honoured in DELAY or RUN.
- cfg_half_period  input  HP_W  `clk` cycles per `gen_clk` phase; 0 is treated as 1.
- cfg_start_delay  input  HP_W  `clk` cycles between start acceptance and the first phase countdown.
- cfg_edge_limit  input  CYC_W  generation ends after edge count exceeds this value.
- gen_clk  output  1  generated clock; registered.
- posedge_pulse  output  1  high for exactly the one `clk` cycle in which `gen_clk` rises.
- cyc_count  output  CYC_W  number of `gen_clk` rising edges since last start.
- cyc_odd  output  1  `cyc_count[0]`.
- busy  output  1  high in DELAY, RUN and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, `rst_n` low): state=IDLE. All outputs 0 (`gen_clk`, `posedge_pulse`, `cyc_count`, `cyc_odd`, `busy`, `done`). Internal counters 0.
- Reset mid-operation has the same effect, applied immediately; no `done` is emitted.
- States: IDLE, DELAY, RUN, DONE.
- IDLE, on `start`=1 and `stop`=0:
  - Latch `H = max(cfg_half_period, 1)`, `D = cfg_start_delay`, `L = cfg_edge_limit`.
  - Clear `cyc_count`.
  - Next state is DELAY if D>0, else RUN.
- IDLE, `start` and `stop` both high: stay in IDLE; `stop` wins.
- DELAY: counts D `clk` cycles, then enters RUN. Phase counter is loaded with H-1 on RUN entry.
- RUN:
  - Phase counter decrements each cycle.
  - At 0: toggle `gen_clk` and reload H-1.
  - On a 0→1 toggle: `posedge_pulse`=1 in the same registered cycle, and `cyc_count` increments in the same cycle.
- Timing for start accepted at edge S: posedge k (1-based) appears at edge S+D+(2k-1)·H.
  - Example: D=0, H=10 gives posedges at S+10, S+30, S+50, ...
- End condition: when the incremented `cyc_count` > L, the next state is DONE.
  - That edge's `posedge_pulse` still fires.
  - L=0 therefore yields exactly one posedge.
- DONE (one cycle): `done`=1, `gen_clk` forced 0, `busy`=1. Next state is IDLE.
  - `cyc_count` holds its final value L+1 until the next accepted start.
- `stop` in DELAY or RUN:
  - Next cycle: IDLE, `gen_clk`=0, `busy`=0, no `done`.
  - `cyc_count` holds its value.
  - `stop` takes priority over a simultaneous end condition.
- `start` while busy: ignored.
- `cfg_*` changes while busy: ignored, because values were latched at start.
- `cyc_count` saturates at all-ones; it cannot wrap before the end condition because L ≤ 2^CYC_W−2 is required, and L = all-ones never terminates except by `stop`.
- Phase counter arithmetic is unsigned HP_W bits. The maximum half-period is 2^HP_W−1.

Decomposition:
- Package `edge_clock_gen_pkg`:
  - state enum (IDLE, DELAY, RUN, DONE);
  - `MIN_HALF_PERIOD`=1.
- One sub-module `phase_timer`:
  - HP_W down-counter with load value, load strobe and enable;
  - emits a `zero` flag;
  - used for both the start delay and the phase countdown.

Test Plan:
- H=10, D=0, L=20, start at edge S:
  - 21 `posedge_pulse`s at S+10+20k;
  - `cyc_odd` alternates 1,0,1…;
  - `done` at S+411;
  - `cyc_count`=21 held; `gen_clk`=0 after.
- H=1, D=5, L=0:
  - single posedge at S+6;
  - `done` at S+7;
  - `cyc_count`=1.
- H=0 is treated as 1:
  - with D=0, L=2, `gen_clk` toggles every cycle;
  - posedges at S+1, S+3, S+5;
  - `done` at S+6.
- `stop` asserted at S+35 with H=10, L=20:
  - IDLE and `gen_clk`=0 at S+36;
  - `cyc_count`=2;
  - no `done`.
- `start`+`stop` asserted together in IDLE: no state change, `busy` stays 0. A later `start` while busy is ignored: the edge schedule is unchanged.
- `rst_n` dropped during RUN (asynchronously, between edges): all outputs 0 immediately. A restart after release reproduces the first scenario's timing.

Source files
------------

// File: rtl/edge_clock_gen_pkg.sv
// Shared types and constants for the edge_clock_gen generator.
package edge_clock_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Smallest usable half-period; a programmed 0 is promoted to this.
  localparam int MIN_HALF_PERIOD = 1;

endpackage

// File: rtl/edge_clock_gen_phase_timer.sv
// Loadable down-counter shared by the start delay and the phase countdown.
// It stops at zero rather than wrapping; the owner reloads it when needed.
module phase_timer #(
  parameter int HP_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [HP_W-1:0] load_val,
  input  logic            en,
  output logic            zero
);

  logic [HP_W-1:0] count;

  // Load takes priority over the decrement; the count parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/edge_clock_gen.sv
// Derived slow clock generator with start delay, rising-edge counting and
// automatic stop after a programmed number of rising edges.
module edge_clock_gen
  import edge_clock_gen_pkg::*;
#(
  parameter int HP_W  = 16,
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [HP_W-1:0]  cfg_half_period,
  input  logic [HP_W-1:0]  cfg_start_delay,
  input  logic [CYC_W-1:0] cfg_edge_limit,
  output logic             gen_clk,
  output logic             posedge_pulse,
  output logic [CYC_W-1:0] cyc_count,
  output logic             cyc_odd,
  output logic             busy,
  output logic             done
);

  state_t state;
  state_t next_state;

  logic [HP_W-1:0]  h_eff;
  logic [HP_W-1:0]  h_m1;
  logic [CYC_W-1:0] limit;

  logic             tmr_load;
  logic [HP_W-1:0]  tmr_val;
  logic             tmr_en;
  logic             tmr_zero;
  logic             accept;
  logic             toggle;

  // Half-period as it would be latched right now, with 0 promoted to 1.
  assign h_eff = (cfg_half_period < HP_W'(MIN_HALF_PERIOD)) ?
                 HP_W'(MIN_HALF_PERIOD) : cfg_half_period;

  phase_timer #(.HP_W(HP_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and timer control; stop beats both start and the end condition.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = h_m1;
    tmr_en     = 1'b0;
    accept     = 1'b0;
    toggle     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          accept   = 1'b1;
          tmr_load = 1'b1;
          if (cfg_start_delay != '0) begin
            next_state = DELAY;
            tmr_val    = cfg_start_delay - 1'b1;
          end else begin
            next_state = RUN;
            tmr_val    = h_eff - 1'b1;
          end
        end
      end
      DELAY: begin
        if (stop) begin
          next_state = IDLE;
        end else if (tmr_zero) begin
          next_state = RUN;
          tmr_load   = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          next_state = IDLE;
        end else if (cyc_count > limit) begin
          next_state = DONE;
        end else if (tmr_zero) begin
          toggle   = 1'b1;
          tmr_load = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Latched configuration, generated clock, edge pulse and saturating edge count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_m1          <= '0;
      limit         <= '0;
      gen_clk       <= 1'b0;
      posedge_pulse <= 1'b0;
      cyc_count     <= '0;
    end else begin
      posedge_pulse <= toggle && !gen_clk;
      if (accept) begin
        h_m1      <= h_eff - 1'b1;
        limit     <= cfg_edge_limit;
        cyc_count <= '0;
        gen_clk   <= 1'b0;
      end else if (toggle) begin
        gen_clk <= !gen_clk;
        if (!gen_clk && (cyc_count != '1)) begin
          cyc_count <= cyc_count + 1'b1;
        end
      end else if (next_state != RUN) begin
        gen_clk <= 1'b0;
      end
    end
  end

  assign cyc_odd = cyc_count[0];
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule
